// File: rtl/multiplexer_bus_n_reg.sv
// Registered N-input bus mux with latched select, auto-scan, Valid/Wrap strobes.
// Optional MULTIPLEXER_BUS_HOLD_EN: Enable=0 holds MuxOut instead of clearing.
//
// Ports:
//   Clock, nReset     : clock, async active-low reset
//   Enable            : output enable (low clears or holds MuxOut)
//   MuxIn             : flattened inputs, input k at [k*NrOfBits +: NrOfBits]
//   Sel, Load         : select value and its capture strobe
//   Scan, Step        : auto-scan mode and its advance strobe
//   MuxOut, CurSel    : registered data and current select
//   Valid, Wrap       : new-selection strobe, scan wrap strobe
module multiplexer_bus_n_reg #(
  parameter int NrOfBits    = 8,
  parameter int NrOfSelBits = 2
) (
  input  logic                               Clock,
  input  logic                               nReset,
  input  logic                               Enable,
  input  logic [(2**NrOfSelBits)*NrOfBits-1:0] MuxIn,
  input  logic [NrOfSelBits-1:0]             Sel,
  input  logic                               Load,
  input  logic                               Scan,
  input  logic                               Step,
  output logic [NrOfBits-1:0]                MuxOut,
  output logic [NrOfSelBits-1:0]             CurSel,
  output logic                               Valid,
  output logic                               Wrap
);

  localparam int NrOfInputs = 2**NrOfSelBits;

  logic [NrOfBits-1:0]    in_word [NrOfInputs];
  logic [NrOfSelBits-1:0] sel_q;
  logic [NrOfSelBits-1:0] sel_d;
  logic                   scan_step;
  logic                   sel_event;
  logic                   wrap_d;
  logic [NrOfBits-1:0]    data_d;
  logic [NrOfBits-1:0]    out_q;
  logic                   valid_q;
  logic                   wrap_q;

  for (genvar k = 0; k < NrOfInputs; k++) begin : g_unpack
    assign in_word[k] = MuxIn[k*NrOfBits +: NrOfBits];
  end

  assign scan_step = Scan & Step;
  assign sel_event = Load | scan_step;

  // Load beats Step; the wrap flag only comes from a real scan step.
  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (Load) begin
      sel_d = Sel;
    end else if (scan_step) begin
      if (sel_q == {NrOfSelBits{1'b1}}) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + 1'b1;
      end
    end
  end

  // Output follows the select being written this edge, so
  // CurSel and MuxOut move together.
  assign data_d = in_word[sel_d];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= sel_event & Enable;
      wrap_q  <= wrap_d;
      if (Enable) begin
        out_q <= data_d;
      end else begin
`ifdef MULTIPLEXER_BUS_HOLD_EN
        out_q <= out_q;
`else
        out_q <= '0;
`endif
      end
    end
  end

  assign MuxOut = out_q;
  assign CurSel = sel_q;
  assign Valid  = valid_q;
  assign Wrap   = wrap_q;

endmodule

// File: tb/tb_multiplexer_bus_n_reg.sv
// Self-checking bench for multiplexer_bus_n_reg: directed plan plus
// randomized traffic against a behavioural model.
module tb_multiplexer_bus_n_reg;

  localparam int B = 8;
  localparam int S = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N*B-1:0] mux_in;
  logic [S-1:0]   sel;
  logic           load;
  logic           scan;
  logic           step;
  logic [B-1:0]   mux_out;
  logic [S-1:0]   cur_sel;
  logic           valid;
  logic           wrap;

  multiplexer_bus_n_reg #(
    .NrOfBits   (B),
    .NrOfSelBits(S)
  ) dut (
    .Clock (clk),
    .nReset(rst_n),
    .Enable(en),
    .MuxIn (mux_in),
    .Sel   (sel),
    .Load  (load),
    .Scan  (scan),
    .Step  (step),
    .MuxOut(mux_out),
    .CurSel(cur_sel),
    .Valid (valid),
    .Wrap  (wrap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int         m_sel;
  logic [7:0] m_out;
  bit         m_valid;
  bit         m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] word_of(input logic [31:0] v, input int k);
    return 8'((v >> (8 * k)) & 32'hFF);
  endfunction

  task automatic model_reset();
    m_sel   = 0;
    m_out   = 8'h00;
    m_valid = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},   32'(mux_out), 32'(m_out));
    chk({tag, ".sel"},   32'(cur_sel), 32'(m_sel));
    chk({tag, ".valid"}, 32'(valid),   32'(m_valid));
    chk({tag, ".wrap"},  32'(wrap),    32'(m_wrap));
  endtask

  // One clock edge: model sees the inputs as driven at the edge,
  // outputs are compared 1 time unit later.
  task automatic cyc(input string tag);
    bit stepping;
    @(posedge clk);
    stepping = scan && step;
    m_wrap   = 1'b0;
    if (load) begin
      m_sel = int'(sel);
    end else if (stepping) begin
      m_wrap = (m_sel == N - 1);
      m_sel  = (m_sel + 1) % N;
    end
    m_valid = (load || stepping) && en;
    if (en) m_out = word_of(mux_in, m_sel);
`ifndef MULTIPLEXER_BUS_HOLD_EN
    else m_out = 8'h00;
`endif
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit l, input int s, input bit sc,
                        input bit st, input bit e);
    load = l;
    sel  = S'(s);
    scan = sc;
    step = st;
    en   = e;
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    mux_in = 32'h44332211;
    set_in(0, 0, 0, 0, 1);
    model_reset();
    #1;
    check_all("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cyc("first");
    chk("first_11", 32'(mux_out), 32'h11);

    set_in(1, 2, 0, 0, 1);
    cyc("load2");
    chk("load2_v", 32'(valid), 32'h1);
    chk("load2_d", 32'(mux_out), 32'h33);
    set_in(0, 0, 0, 0, 1);
    cyc("load2_hold");
    chk("hold_33", 32'(mux_out), 32'h33);

    mid_reset("async");
    chk("async_out", 32'(mux_out), 32'h0);
    cyc("post_rst");
    chk("post_rst_11", 32'(mux_out), 32'h11);

    set_in(1, 1, 0, 0, 1);
    cyc("to_sel1");
    set_in(0, 0, 1, 1, 1);
    cyc("scan_a");
    cyc("scan_b");
    chk("scan_b_44", 32'(mux_out), 32'h44);
    cyc("scan_c");
    chk("scan_wrap", 32'(wrap), 32'h1);
    chk("scan_c_11", 32'(mux_out), 32'h11);
    cyc("scan_d");
    chk("scan_d_22", 32'(mux_out), 32'h22);

    set_in(1, 0, 0, 0, 1);
    cyc("to_sel0");
    set_in(1, 3, 1, 1, 1);
    cyc("collide");
    chk("collide_sel", 32'(cur_sel), 32'h3);
    chk("collide_wr", 32'(wrap), 32'h0);

    set_in(1, 2, 0, 0, 1);
    cyc("to_sel2");
    set_in(1, 1, 0, 0, 0);
    cyc("en0_a");
    set_in(0, 0, 0, 0, 0);
    cyc("en0_b");
    chk("en0_sel", 32'(cur_sel), 32'h1);
`ifdef MULTIPLEXER_BUS_HOLD_EN
    chk("en0_hold", 32'(mux_out), 32'h33);
`else
    chk("en0_zero", 32'(mux_out), 32'h0);
`endif
    set_in(0, 0, 0, 0, 1);
    cyc("reen");
    chk("reen_22", 32'(mux_out), 32'h22);

    set_in(1, 3, 0, 0, 1);
    cyc("to_sel3");
    set_in(0, 0, 0, 0, 1);
    mux_in[31:24] = 8'hA5;
    cyc("track");
    chk("track_a5", 32'(mux_out), 32'hA5);
    chk("track_v", 32'(valid), 32'h0);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) mux_in = $urandom();
      cyc("rnd");
      if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiplexer_bus_n_reg.md
Name: multiplexer_bus_n_reg

Overview:
- Parametrised, registered N-input bus multiplexer; successor to the 2-input combinational bus mux.
- Adds a latched select register, an auto-scan mode that steps through inputs, a registered output and a valid strobe.
- Used on the 6502 datapath where bus sources are chosen synchronously, e.g. the ALU operand feed and the address-bus source.

Parameters:
- NrOfBits, 8, data width of each input and of the output.
- NrOfSelBits, 2, select width; number of inputs NrOfInputs = 2**NrOfSelBits.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous active-low reset.
- Enable  in  1  output enable; low forces a zero output (see Optional Feature).
- MuxIn  in  NrOfInputs*NrOfBits  flattened inputs; input k occupies bits [k*NrOfBits +: NrOfBits].
- Sel  in  NrOfSelBits  select value, captured on Load.
- Load  in  1  strobe: capture Sel into the select register.
- Scan  in  1  mode: 0 = direct, 1 = auto-scan.
- Step  in  1  strobe in scan mode: advance the select register.
- MuxOut  out  NrOfBits  registered selected data.
- CurSel  out  NrOfSelBits  current select register value.
- Valid  out  1  high for exactly one cycle when MuxOut first reflects a new selection.
- Wrap  out  1  one-cycle pulse when a scan step wraps from NrOfInputs-1 to 0.

Behaviour:
- Reset (nReset low, asynchronous): select register = 0, MuxOut = 0, Valid = 0, Wrap = 0. All outputs are held at these values while nReset is low.
- Reset release: synchronous to Clock; the first active edge after deassertion operates normally.
- Select register update, priority per rising edge:
  - Load=1: sel <= Sel. Load wins over Step.
  - Otherwise Scan=1 and Step=1: sel <= (sel == NrOfInputs-1) ? 0 : sel+1.
  - Otherwise: sel holds.
  - Step is ignored when Scan=0.
- Output register, every rising edge:
  - Enable=1: MuxOut <= MuxIn[next_sel], where next_sel is the select-register value being written on the same edge.
  - Latency: one edge from Load/Step to MuxOut and CurSel updating together. Data changes on MuxIn with no select change appear on MuxOut one edge later.
  - Enable=0: MuxOut <= 0. The select register still updates, so Enable does not gate Load or Step.
- Valid:
  - Registered; high on the cycle after an edge where Load=1, or Scan=1 and Step=1, and Enable=1.
  - Asserted even if the new select equals the old one.
  - Low otherwise.
- Wrap:
  - Registered; high on the cycle after a scan step from NrOfInputs-1 to 0.
  - Not asserted by a Load of 0.
- Mode change mid-scan: Scan going 0 simply freezes sel; no reset of the counter.
- Sel width is exactly NrOfSelBits, so there are no out-of-range selects.
- Boundary: NrOfSelBits=1 gives the 2-input case. Its output equals the predecessor's output delayed one cycle, with Load tied high in direct mode.

Optional Feature:
- Macro: MULTIPLEXER_BUS_HOLD_EN.
- Defined: Enable=0 holds MuxOut at its last value instead of clearing it. Valid is still suppressed while Enable=0.
- Not defined: Enable=0 drives MuxOut to 0 on the next edge, matching predecessor semantics.
- Reset value is 0 in both builds.

Test Plan:
- Reset: NrOfBits=8, NrOfSelBits=2, MuxIn={8'h44,8'h33,8'h22,8'h11}, nReset pulsed low mid-cycle -> MuxOut=0, CurSel=0, Valid=0 immediately (asynchronous). First edge after release with Enable=1 -> MuxOut=8'h11.
- Direct load: Load=1, Sel=2 for one edge -> next cycle CurSel=2, MuxOut=8'h33, Valid=1. Following cycle Valid=0 and MuxOut stays 8'h33.
- Scan wrap: Scan=1, Step=1 for 4 edges from sel=1 -> CurSel 2,3,0,1; MuxOut 8'h33,8'h44,8'h11,8'h22; Wrap=1 only on the cycle CurSel=0.
- Load vs Step collision: Scan=1, Step=1, Load=1, Sel=3 from sel=0 -> CurSel=3 (not 1), Valid=1, Wrap=0.
- Enable low: with sel=2, Enable=0 for 2 edges, Load Sel=1 during that time -> MuxOut=0 and Valid=0 (default build), or MuxOut=8'h33 held (hold build). CurSel=1 in both builds. Re-enable -> MuxOut=8'h22 after one edge.
- Data tracking: sel=3 fixed, MuxIn[3] changes 8'h44->8'hA5 -> MuxOut=8'hA5 one edge later, Valid stays 0.
